ps2_key_tracker: RTL
====================

# ps2_key_tracker

Parametrised PS/2 scan-code interpreter sitting between `ps2_keyboard` (FIFO-backed receiver) and display/LED logic. Pops bytes with the receiver's `ready`/`nextdata_n` handshake, decodes the E0 (extended) and F0 (break) prefixes, and tracks the currently held key. It emits one-cycle make/break/repeat events and keeps a press counter that ignores typematic auto-repeat. Successor to the single-FSM decoder in `top`: configurable counter width, wrap or saturate mode, extended-key support, error and overflow reporting.

## Interface
- `CNT_W`, 8, press-counter width (1..16)
- `CNT_SAT`, 0, 0 = counter wraps modulo 2^CNT_W; 1 = counter saturates at all-ones
- `REP_CNT`, 0, 1 = auto-repeat makes also increment the counter
- `clk` in 1 — single clock, all logic on posedge
- `rst` in 1 — asynchronous, active-high reset
- `ready` in 1 — receiver FIFO non-empty; `data` valid while high
- `data` in 8 — head byte of receiver FIFO
- `overflow` in 1 — receiver FIFO overflow indication
- `clr` in 1 — synchronous clear of `press_cnt` and `ovf_sticky`
- `nextdata_n` out 1 — active-low pop strobe to receiver, one cycle per byte
- `evt_valid` out 1 — one-cycle event strobe
- `evt_code` out 8 — scan code of event (prefixes stripped)
- `evt_ext` out 1 — event carried E0 prefix
- `evt_break` out 1 — event is a release
- `evt_repeat` out 1 — make of a key already held
- `key_held` out 1 — a key is currently held
- `key_code` out 8 — held key code; 0 when none held
- `key_ext` out 1 — held key is extended
- `last_code` out 8 — code of the most recent new press
- `press_cnt` out CNT_W — count of new presses
- `err` out 1 — one-cycle pulse on 0x00/0xFF byte
- `ovf_sticky` out 1 — set when `overflow` is seen high; cleared only by `clr`/`rst`

## Operation
- Decode FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
- Byte 0xE0: IDLE→EXT, BRK→EXT_BRK, EXT/EXT_BRK stay. No event.
- Byte 0xF0: IDLE→BRK, EXT→EXT_BRK, BRK/EXT_BRK stay. No event.
- Byte 0x00 or 0xFF: discarded; `err` pulses; FSM→IDLE; held-key state unchanged.
- Any other byte b in IDLE/EXT: make event with `evt_code`=b and `evt_ext`=(state==EXT); FSM→IDLE.
  - If `key_held` and {b, ext} matches {`key_code`,`key_ext`}: `evt_repeat`=1; counter increments only when REP_CNT=1.
  - Otherwise: new press; `key_code`=b, `key_ext`=ext, `key_held`=1, `last_code`=b, counter increments.
- Other byte b in BRK/EXT_BRK: break event (`evt_break`=1); if {b, ext} matches the held key, `key_held`=0, `key_code`=0 and `key_ext`=0; otherwise held state is unchanged. FSM→IDLE.
- Counter: on increment at all-ones, wraps to 0 (CNT_SAT=0) or holds (CNT_SAT=1). `clr` takes priority over a same-cycle increment, so the result is 0.
- `ovf_sticky`: set in any cycle `overflow`=1. If `clr` and `overflow` are both high, it stays set.

## Timing
- Reset values: `nextdata_n`=1; FSM=IDLE; all other outputs 0.
- Cycle T: `ready`=1 and no pop pending → byte sampled. In T+1: `nextdata_n`=0 for exactly one cycle, and the FSM, event and held-key outputs reflect the byte. `evt_valid`/`err` are high only in T+1.
- T+1 is a gap cycle in which `ready` is ignored. The next sample is possible at T+2, so peak throughput is 1 byte per 2 cycles.
- `ready`=0: no sample; `nextdata_n` stays 1.
- Every byte popped produces exactly one `nextdata_n` low cycle, prefixes included.
- Reset mid-sequence (e.g. after E0): FSM returns to IDLE and the partial prefix is lost.

## Test plan
- Bytes 15, F0, 15 → make evt 0x15; break evt 0x15; `press_cnt`=1, `last_code`=0x15, `key_held` 1 then 0; 3 `nextdata_n` pulses.
- Bytes 1C,1C,1C,F0,1C with REP_CNT=0 → 1 new make + 2 `evt_repeat`; `press_cnt`=1; with REP_CNT=1 → `press_cnt`=3.
- Bytes E0,75,E0,F0,75 → make `evt_ext`=1 code 0x75, `key_ext`=1; then break ext 0x75, `key_held`=0; no events on prefix bytes.
- CNT_W=2: 5 distinct press/release pairs → `press_cnt` 1,2,3,0,1 (CNT_SAT=0); 1,2,3,3,3 (CNT_SAT=1); `clr` with a same-cycle make → 0.
- Bytes E0,FF,23 → `err` pulse, then make 0x23 with `evt_ext`=0; `overflow` pulse → `ovf_sticky`=1 until `clr`.
- `ready` held high with 4 queued bytes → `nextdata_n` low on alternate cycles only; assert `rst` after F0 → all outputs 0, and the next byte 23 is decoded as a make.

Source files
------------

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_tracker
//  Purpose  : Pops PS/2 scan-code bytes from a FIFO-backed receiver, strips
//             the E0 (extended) and F0 (break) prefixes, emits one-cycle
//             make/break/repeat events, tracks the single held key and keeps
//             a press counter that ignores typematic auto-repeat (optional).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_tracker #(
  parameter int CNT_W   = 8,   // press-counter width, 1..16
  parameter int CNT_SAT = 0,   // 0: wrap modulo 2^CNT_W, 1: saturate at all-ones
  parameter int REP_CNT = 0    // 1: auto-repeat makes also count
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  input  logic             clr,
  output logic             nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             key_held,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       last_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err,
  output logic             ovf_sticky
);

  localparam logic [7:0] C_BYTE_EXT = 8'hE0;
  localparam logic [7:0] C_BYTE_BRK = 8'hF0;
  localparam logic [7:0] C_BYTE_Z   = 8'h00;
  localparam logic [7:0] C_BYTE_F   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             evt_valid_q,  evt_valid_d;
  logic [7:0]       evt_code_q,   evt_code_d;
  logic             evt_ext_q,    evt_ext_d;
  logic             evt_break_q,  evt_break_d;
  logic             evt_repeat_q, evt_repeat_d;
  logic             key_held_q,   key_held_d;
  logic [7:0]       key_code_q,   key_code_d;
  logic             key_ext_q,    key_ext_d;
  logic [7:0]       last_code_q,  last_code_d;
  logic [CNT_W-1:0] press_cnt_q,  press_cnt_d;
  logic             err_q,        err_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             take;
  logic             cur_ext;
  logic             in_break;
  logic             key_match;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_plus;

  // A byte is only sampled when no pop is outstanding; the pop cycle is the gap
  assign take      = ready & nextdata_n_q;
  assign cur_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign in_break  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign key_match = key_held_q && (data == key_code_q) && (cur_ext == key_ext_q);

  // Incremented counter value: either wraps naturally or sticks at all-ones
  generate
    if (CNT_SAT != 0) begin : g_cnt_sat
      assign cnt_plus = (&press_cnt_q) ? press_cnt_q : press_cnt_q + CNT_W'(1);
    end else begin : g_cnt_wrap
      assign cnt_plus = press_cnt_q + CNT_W'(1);
    end
  endgenerate

  // Next-state decode for the prefix FSM, events, held key and counters
  always_comb begin
    state_d      = state_q;
    nextdata_n_d = 1'b1;
    evt_valid_d  = 1'b0;
    evt_code_d   = 8'h00;
    evt_ext_d    = 1'b0;
    evt_break_d  = 1'b0;
    evt_repeat_d = 1'b0;
    key_held_d   = key_held_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    last_code_d  = last_code_q;
    err_d        = 1'b0;
    cnt_inc      = 1'b0;

    if (take) begin
      nextdata_n_d = 1'b0;
      if (data == C_BYTE_EXT) begin
        // Extended prefix may follow or precede nothing else; F0 then E0 keeps break
        state_d = in_break ? ST_EXT_BRK : ST_EXT;
      end else if (data == C_BYTE_BRK) begin
        state_d = cur_ext ? ST_EXT_BRK : ST_BRK;
      end else if ((data == C_BYTE_Z) || (data == C_BYTE_F)) begin
        // Receiver error/overrun codes: drop the byte and any pending prefix
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (in_break) begin
        evt_valid_d = 1'b1;
        evt_code_d  = data;
        evt_ext_d   = cur_ext;
        evt_break_d = 1'b1;
        if (key_match) begin
          key_held_d = 1'b0;
          key_code_d = 8'h00;
          key_ext_d  = 1'b0;
        end
        state_d = ST_IDLE;
      end else begin
        evt_valid_d = 1'b1;
        evt_code_d  = data;
        evt_ext_d   = cur_ext;
        if (key_match) begin
          evt_repeat_d = 1'b1;
          cnt_inc      = (REP_CNT != 0);
        end else begin
          key_held_d  = 1'b1;
          key_code_d  = data;
          key_ext_d   = cur_ext;
          last_code_d = data;
          cnt_inc     = 1'b1;
        end
        state_d = ST_IDLE;
      end
    end

    // Clear wins over a same-cycle increment
    if (clr) begin
      press_cnt_d = '0;
    end else if (cnt_inc) begin
      press_cnt_d = cnt_plus;
    end else begin
      press_cnt_d = press_cnt_q;
    end

    // Overflow wins over clear so a coincident overflow is never lost
    if (overflow) begin
      ovf_sticky_d = 1'b1;
    end else if (clr) begin
      ovf_sticky_d = 1'b0;
    end else begin
      ovf_sticky_d = ovf_sticky_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_repeat_q <= 1'b0;
      key_held_q   <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      last_code_q  <= 8'h00;
      press_cnt_q  <= '0;
      err_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_break_q  <= evt_break_d;
      evt_repeat_q <= evt_repeat_d;
      key_held_q   <= key_held_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      last_code_q  <= last_code_d;
      press_cnt_q  <= press_cnt_d;
      err_q        <= err_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_break  = evt_break_q;
  assign evt_repeat = evt_repeat_q;
  assign key_held   = key_held_q;
  assign key_code   = key_code_q;
  assign key_ext    = key_ext_q;
  assign last_code  = last_code_q;
  assign press_cnt  = press_cnt_q;
  assign err        = err_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule
`default_nettype wire
